// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver for the USB-UART RX FIFO.
// Mid-bit sampling with a per-frame latched baud divider.
module uart_rx_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       rx_i,
  input  logic [2:0] baudsel_i,
  input  logic       fifo_full_i,
  output logic [7:0] rx_data_o,
  output logic       rx_wr_o,
  output logic       ferr_o,
  output logic       ovr_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic                   rxs_d;
  logic [12:0]            timer;
  logic [12:0]            div;
  logic [12:0]            div_nx;
  logic [12:0]            half_nx;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;

  function automatic logic [12:0] div_of(
    input logic [2:0] sel
  );
    logic [12:0] d;
    d = 13'd5000;
    unique case (sel)
      3'd0: d = 13'd5000;
      3'd1: d = 13'd2500;
      3'd2: d = 13'd1250;
      3'd3: d = 13'd833;
      3'd4: d = 13'd417;
      3'd5: d = 13'd208;
      3'd6: d = 13'd48;
      3'd7: d = 13'd16;
      default: d = 13'd5000;
    endcase
    return d;
  endfunction

  assign rxs     = sync[SYNC_STAGES-1];
  assign div_nx  = div_of(baudsel_i);
  assign half_nx = (div_nx >> 1) - 13'd1;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      sync      <= '1;
      rxs_d     <= 1'b1;
      state     <= IDLE;
      timer     <= '0;
      div       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data_o <= '0;
      rx_wr_o   <= 1'b0;
      ferr_o    <= 1'b0;
      ovr_o     <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rx_i};
      rxs_d     <= rxs;
      rx_data_o <= '0;
      rx_wr_o   <= 1'b0;
      ferr_o    <= 1'b0;
      ovr_o     <= 1'b0;
      unique case (state)
        IDLE: begin
          // divider is frozen here so mid-frame baud changes wait a frame
          if (rxs_d && !rxs) begin
            div   <= div_nx;
            timer <= half_nx;
            state <= START;
          end
        end
        START: begin
          if (timer == '0) begin
            if (!rxs) begin
              timer  <= div - 13'd1;
              bitcnt <= '0;
              state  <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 13'd1;
          end
        end
        DATA: begin
          if (timer == '0) begin
            shreg <= {rxs, shreg[7:1]};
            timer <= div - 13'd1;
            if (bitcnt == 3'd7) begin
              state <= STOP;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end else begin
            timer <= timer - 13'd1;
          end
        end
        STOP: begin
          if (timer == '0) begin
            if (rxs) begin
              if (fifo_full_i) begin
                ovr_o <= 1'b1;
              end else begin
                rx_wr_o   <= 1'b1;
                rx_data_o <= shreg;
              end
              state <= IDLE;
            end else begin
              ferr_o <= 1'b1;
              state  <= BRK;
            end
          end else begin
            timer <= timer - 13'd1;
          end
        end
        BRK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Asynchronous serial receiver feeding the USB-UART RX FIFO. The UART register block exposes this FIFO through USB_UART_STAT ($9F56) and USB_UART_DATA ($9F57).
- Runs in the NORA system clock domain and deserialises 8N1 frames from UART_RX.
- Baud rate comes from the 3-bit field of USB_UART_CTRL ($9F55).
- Delivers one byte per frame as a single-cycle write strobe into the FIFO, and flags framing and overrun errors.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser for rx_i (minimum 2).

Ports:
- clk6x  input  1  system clock, 48 MHz.
- resetn  input  1  reset; asynchronous, active-low.
- rx_i  input  1  raw UART_RX pin; idle high.
- baudsel_i  input  3  baud select from USB_UART_CTRL[2:0].
- fifo_full_i  input  1  RX FIFO full.
- rx_data_o  output  8  received byte, valid only while rx_wr_o=1.
- rx_wr_o  output  1  one-cycle FIFO write strobe.
- ferr_o  output  1  one-cycle framing-error strobe.
- ovr_o  output  1  one-cycle overrun strobe.
- busy_o  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset values: all outputs 0; synchroniser flops 1; state IDLE; counters 0. Reset mid-frame aborts the frame silently.
- Synchroniser: rx_i passes through SYNC_STAGES flops to give rxs. All logic uses rxs only.
- Clocks per bit (DIV) by baudsel_i:
  - 0 = 5000 (9600 Bd)
  - 1 = 2500
  - 2 = 1250
  - 3 = 833
  - 4 = 417 (115200 Bd)
  - 5 = 208
  - 6 = 48 (1 Mbd)
  - 7 = 16 (3 Mbd)
- DIV is latched at start-bit detection. A baudsel_i change mid-frame takes effect on the next frame.
- Bit timer: 13-bit down-counter. Bit index: 3-bit counter.
- State IDLE:
  - Falling edge of rxs (previous 1, current 0) loads timer = DIV/2 − 1 (integer floor) and goes to START.
- State START:
  - On timer = 0, sample rxs.
  - rxs = 0: load timer = DIV − 1, clear bit index, go to DATA.
  - rxs = 1: glitch; return to IDLE with no strobe.
- State DATA:
  - On each timer expiry, shift rxs into the MSB of an 8-bit shift register (LSB first on the line) and reload timer = DIV − 1.
  - After bit index 7, go to STOP.
- State STOP:
  - On timer expiry, sample rxs.
  - rxs = 1 and fifo_full_i = 0: the next cycle drives rx_wr_o = 1 and rx_data_o = shift register, then IDLE.
  - rxs = 1 and fifo_full_i = 1: ovr_o = 1 for one cycle, byte dropped, rx_wr_o stays 0, then IDLE.
  - rxs = 0: ferr_o = 1 for one cycle, byte dropped, go to BREAK.
- State BREAK:
  - Wait until rxs = 1, then go to IDLE.
  - A line held low (break condition) yields exactly one ferr_o and no further events.
- fifo_full_i is sampled only in the stop-bit sample cycle.
- Strobes are mutually exclusive and never asserted in consecutive cycles.
- Latency: rx_wr_o rises SYNC_STAGES + 1 + (DIV/2 + 9·DIV) clocks after the falling edge on rx_i, tolerance ±1 clock.
- A new start bit is accepted from the first IDLE cycle after the strobe, so back-to-back frames with no idle gap are received.

Test Plan:
- baudsel = 6, send 0xA5 (8N1), FIFO not full.
  - Required: a single rx_wr_o pulse with rx_data_o = 0xA5, 458±2 clocks after the start edge.
  - Required: busy_o low afterwards.
- baudsel = 6, send 12 back-to-back bytes 0xA5–0xA9, 0xB0–0xB6 with no idle gap.
  - Required: 12 rx_wr_o pulses in order with the matching data.
  - Required: no ferr_o or ovr_o.
- Low glitch of 10 clocks at baudsel = 6 (less than DIV/2 = 24).
  - Required: no strobes.
  - Required: busy_o high for about 24 clocks, then IDLE.
- baudsel = 6, byte 0x3C with the stop bit driven 0, then line held low for 30 bit times.
  - Required: exactly one ferr_o and no rx_wr_o.
  - Required: after the line returns high, byte 0x12 is received correctly.
- fifo_full_i = 1 during the stop bit of 0x55.
  - Required: ovr_o pulses once and rx_wr_o stays 0.
  - Required: the next byte, 0x66, with full deasserted, is written.
- baudsel = 4 byte 0xC3.
  - Required: correct receive at 417 clocks/bit.
- Same setup, resetn pulsed low mid-DATA.
  - Required: no strobe and outputs return to 0.
  - Required: the following 0x81 is received correctly.
